// File: rtl/sensor_event_frontend.sv
// sensor_event_frontend
// Conditions the raw track-sensor lines for the train controller: two-flop
// synchronizer, per-channel debounce, rising-edge (arrival) detection, a
// one-bit pending flag per channel and a lowest-index arbiter that presents
// one sensor-numbered event at a time over a valid/ready handshake.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   sensor_raw    raw sensor lines, bit 0 = S1, asynchronous to clk
//   sensor_level  debounced sensor levels
//   event_valid   an event is presented
//   event_id      sensor number 1..N_SENS of the presented event, 0 when idle
//   event_ready   downstream accepts the presented event this cycle
//   overflow      sticky: an arrival merged into an already-pending one
//   clr_overflow  synchronous clear of overflow (a coincident set wins)
module sensor_event_frontend #(
    parameter int unsigned N_SENS          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] sensor_raw,
    output logic [N_SENS-1:0] sensor_level,
    output logic              event_valid,
    output logic [2:0]        event_id,
    input  logic              event_ready,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned      ID_W    = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SENS-1:0] sync1;
    logic [N_SENS-1:0] sync2;
    logic [N_SENS-1:0] stable;
    logic [N_SENS-1:0] pending;
    logic [CNT_W-1:0]  cnt [N_SENS];

    logic [N_SENS-1:0] flip_c;
    logic [N_SENS-1:0] rise_c;
    logic [N_SENS-1:0] consume_c;
    logic [N_SENS-1:0] ovf_set_c;
    logic              load_c;
    logic              grant_c;
    logic [ID_W-1:0]   grant_id_c;

    // Debounce decision: a level change is accepted on its DEBOUNCE_CYCLES-th stable cycle
    always_comb begin
        flip_c = '0;
        rise_c = '0;
        for (int unsigned k = 0; k < N_SENS; k++) begin
            flip_c[k] = (sync2[k] != stable[k]) && (cnt[k] == CNT_MAX);
            rise_c[k] = flip_c[k] && sync2[k];
        end
    end

    // Output register is free when empty or being accepted; lowest pending index wins
    always_comb begin
        load_c     = !event_valid || event_ready;
        grant_c    = 1'b0;
        grant_id_c = '0;
        consume_c  = '0;
        for (int unsigned k = 0; k < N_SENS; k++) begin
            if (pending[k] && !grant_c) begin
                grant_c      = 1'b1;
                grant_id_c   = ID_W'(k + 1);
                consume_c[k] = load_c;
            end
        end
        ovf_set_c = rise_c & pending & ~consume_c;
    end

    // Synchronizer, debounce counters, pending flags, output register, overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            pending     <= '0;
            event_valid <= 1'b0;
            event_id    <= '0;
            overflow    <= 1'b0;
            for (int unsigned k = 0; k < N_SENS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1 <= sensor_raw;
            sync2 <= sync1;
            for (int unsigned k = 0; k < N_SENS; k++) begin
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (flip_c[k]) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
            // A consumed bit re-arms if a new arrival lands on the same edge
            pending <= (pending & ~consume_c) | rise_c;
            if (load_c) begin
                event_valid <= grant_c;
                event_id    <= grant_id_c;
            end
            if (|ovf_set_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign sensor_level = stable;

endmodule

// File: tb/tb_sensor_event_frontend.sv
// Directed bench for sensor_event_frontend with DEBOUNCE_CYCLES=4.
module tb_sensor_event_frontend;

    localparam int unsigned N_SENS = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_SENS-1:0] sensor_raw;
    logic [N_SENS-1:0] sensor_level;
    logic              event_valid;
    logic [2:0]        event_id;
    logic              event_ready;
    logic              overflow;
    logic              clr_overflow;

    int total = 0;
    int bad   = 0;

    sensor_event_frontend #(
        .N_SENS         (N_SENS),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_raw  (sensor_raw),
        .sensor_level(sensor_level),
        .event_valid (event_valid),
        .event_id    (event_id),
        .event_ready (event_ready),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past n rising edges; sampling/driving happens 1 time unit later
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet(input string tag, input int n);
        repeat (n) begin
            tick(1);
            chk(tag, {31'd0, event_valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        sensor_raw   = '0;
        event_ready  = 1'b1;
        clr_overflow = 1'b0;
        #2;
        chk("rst_valid", {31'd0, event_valid}, 32'd0);
        chk("rst_id", {29'd0, event_id}, 32'd0);
        chk("rst_level", {26'd0, sensor_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        quiet("idle_quiet", 3);

        // Single arrival on S3
        sensor_raw[2] = 1'b1;
        tick(5);
        chk("single_level_e5", {31'd0, sensor_level[2]}, 32'd0);
        tick(1);
        chk("single_level_e6", {31'd0, sensor_level[2]}, 32'd1);
        chk("single_valid_e6", {31'd0, event_valid}, 32'd0);
        tick(1);
        chk("single_valid_e7", {31'd0, event_valid}, 32'd1);
        chk("single_id_e7", {29'd0, event_id}, 32'd3);
        tick(1);
        chk("single_valid_e8", {31'd0, event_valid}, 32'd0);
        chk("single_id_e8", {29'd0, event_id}, 32'd0);
        sensor_raw[2] = 1'b0;
        quiet("fall_no_event", 10);
        chk("fall_level", {31'd0, sensor_level[2]}, 32'd0);

        // Glitch of 3 cycles rejected
        sensor_raw[0] = 1'b1;
        tick(3);
        sensor_raw[0] = 1'b0;
        repeat (10) begin
            tick(1);
            chk("glitch_valid", {31'd0, event_valid}, 32'd0);
            chk("glitch_level", {26'd0, sensor_level}, 32'd0);
        end
        // 4-cycle pulse accepted
        sensor_raw[0] = 1'b1;
        tick(4);
        sensor_raw[0] = 1'b0;
        tick(2);
        chk("pulse_level_e6", {31'd0, sensor_level[0]}, 32'd1);
        tick(1);
        chk("pulse_valid_e7", {31'd0, event_valid}, 32'd1);
        chk("pulse_id_e7", {29'd0, event_id}, 32'd1);
        quiet("pulse_after", 12);

        // Simultaneous arrivals S2 and S6 under backpressure
        event_ready   = 1'b0;
        sensor_raw[5] = 1'b1;
        sensor_raw[1] = 1'b1;
        tick(7);
        chk("simul_valid", {31'd0, event_valid}, 32'd1);
        chk("simul_id", {29'd0, event_id}, 32'd2);
        repeat (10) begin
            tick(1);
            chk("stall_valid", {31'd0, event_valid}, 32'd1);
            chk("stall_id", {29'd0, event_id}, 32'd2);
        end
        event_ready = 1'b1;
        tick(1);
        chk("simul2_valid", {31'd0, event_valid}, 32'd1);
        chk("simul2_id", {29'd0, event_id}, 32'd6);
        tick(1);
        chk("simul_drop", {31'd0, event_valid}, 32'd0);
        chk("simul_drop_id", {29'd0, event_id}, 32'd0);
        sensor_raw = '0;
        quiet("simul_after", 12);

        // Overflow: hold event 1, two arrivals on S4 merge
        event_ready   = 1'b0;
        sensor_raw[0] = 1'b1;
        tick(7);
        chk("ovf_hold_id", {29'd0, event_id}, 32'd1);
        sensor_raw[0] = 1'b0;
        sensor_raw[3] = 1'b1;
        tick(6);
        chk("ovf_first_arr", {31'd0, overflow}, 32'd0);
        sensor_raw[3] = 1'b0;
        tick(6);
        sensor_raw[3] = 1'b1;
        tick(5);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        tick(1);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_still_id1", {29'd0, event_id}, 32'd1);
        event_ready = 1'b1;
        tick(1);
        chk("ovf_ev_valid", {31'd0, event_valid}, 32'd1);
        chk("ovf_ev_id", {29'd0, event_id}, 32'd4);
        quiet("ovf_single", 4);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Clear coincident with new overflow: set wins
        event_ready   = 1'b0;
        sensor_raw[0] = 1'b1;
        sensor_raw[3] = 1'b0;
        tick(7);
        chk("ovc_hold_id", {29'd0, event_id}, 32'd1);
        sensor_raw[3] = 1'b1;
        tick(6);
        sensor_raw[3] = 1'b0;
        tick(6);
        sensor_raw[3] = 1'b1;
        tick(5);
        chk("ovc_before", {31'd0, overflow}, 32'd0);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovc_set_wins", {31'd0, overflow}, 32'd1);
        event_ready = 1'b1;
        tick(1);
        chk("ovc_ev_id", {29'd0, event_id}, 32'd4);
        tick(1);
        chk("ovc_drop", {31'd0, event_valid}, 32'd0);
        clr_overflow = 1'b1;
        sensor_raw   = '0;
        tick(1);
        clr_overflow = 1'b0;
        quiet("ovc_after", 10);

        // Reset mid-operation with an event presented and one pending
        event_ready   = 1'b0;
        sensor_raw[0] = 1'b1;
        sensor_raw[2] = 1'b1;
        tick(7);
        chk("mid_valid", {31'd0, event_valid}, 32'd1);
        chk("mid_id", {29'd0, event_id}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, event_valid}, 32'd0);
        chk("mid_rst_id", {29'd0, event_id}, 32'd0);
        chk("mid_rst_level", {26'd0, sensor_level}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        sensor_raw  = '0;
        event_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        quiet("post_rst_quiet", 12);

        // Sensor held high through reset release is a fresh arrival
        rst_n         = 1'b0;
        sensor_raw[4] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("held_valid_e6", {31'd0, event_valid}, 32'd0);
        chk("held_level_e6", {31'd0, sensor_level[4]}, 32'd1);
        tick(1);
        chk("held_valid_e7", {31'd0, event_valid}, 32'd1);
        chk("held_id_e7", {29'd0, event_id}, 32'd5);
        quiet("held_single", 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
